// File: rtl/mrh_wb_arbiter.sv
// Write-back arbiter: per-pipe result FIFOs drained round-robin onto the register-file write ports.
// Optional same-cycle bypass of empty FIFOs is enabled by defining MRH_WB_ARB_BYPASS_EN.
module mrh_wb_arbiter #(
    parameter int IN_PORTS = 2,
    parameter int WR_PORTS = 1,
    parameter int DEPTH    = 4,
    parameter int RNID_W   = 7,
    parameter int XLEN     = 64
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic [IN_PORTS-1:0]        i_tgt_valid,
    input  logic [IN_PORTS*RNID_W-1:0] i_tgt_rnid,
    input  logic [IN_PORTS*XLEN-1:0]   i_tgt_data,
    output logic [IN_PORTS-1:0]        o_stall_req,
    output logic [WR_PORTS-1:0]        o_wr_valid,
    output logic [WR_PORTS*RNID_W-1:0] o_wr_rnid,
    output logic [WR_PORTS*XLEN-1:0]   o_wr_data,
    output logic                       o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = RNID_W + XLEN;
    localparam int PW = (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1;

    logic [EW-1:0]       mem [IN_PORTS][DEPTH];
    logic [AW:0]         wr_ptr [IN_PORTS];
    logic [AW:0]         rd_ptr [IN_PORTS];
    logic [AW:0]         count [IN_PORTS];
    logic [AW:0]         count_next [IN_PORTS];
    logic [EW-1:0]       head [IN_PORTS];
    logic [EW-1:0]       arrival [IN_PORTS];
    logic [IN_PORTS-1:0] empty;
    logic [IN_PORTS-1:0] full;
    logic [IN_PORTS-1:0] cand;
    logic [IN_PORTS-1:0] grant;
    logic [IN_PORTS-1:0] pop;
    logic [IN_PORTS-1:0] push;
    logic [IN_PORTS-1:0] bypass;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       rr_next;
    logic [WR_PORTS-1:0] slot_valid;
    logic [PW-1:0]       slot_src [WR_PORTS];
    logic [EW-1:0]       slot_entry [WR_PORTS];
    logic                overflow_event;

    always_comb begin
        for (int p = 0; p < IN_PORTS; p++) begin
            count[p]   = wr_ptr[p] - rd_ptr[p];
            empty[p]   = (wr_ptr[p] == rd_ptr[p]);
            full[p]    = (wr_ptr[p][AW] != rd_ptr[p][AW]) &&
                         (wr_ptr[p][AW-1:0] == rd_ptr[p][AW-1:0]);
            head[p]    = mem[p][rd_ptr[p][AW-1:0]];
            arrival[p] = {i_tgt_rnid[p*RNID_W +: RNID_W], i_tgt_data[p*XLEN +: XLEN]};
`ifdef MRH_WB_ARB_BYPASS_EN
            cand[p]    = !empty[p] || i_tgt_valid[p];
`else
            cand[p]    = !empty[p];
`endif
        end
    end

    // Walk ports starting at rr_ptr; the n-th candidate found drives write port n.
    always_comb begin
        int n;
        n          = 0;
        grant      = '0;
        slot_valid = '0;
        rr_next    = rr_ptr;
        for (int k = 0; k < WR_PORTS; k++) begin
            slot_src[k] = '0;
        end
        for (int i = 0; i < IN_PORTS; i++) begin
            for (int p = 0; p < IN_PORTS; p++) begin
                if (p == (int'(rr_ptr) + i) % IN_PORTS && cand[p] && n < WR_PORTS) begin
                    grant[p] = 1'b1;
                    for (int k = 0; k < WR_PORTS; k++) begin
                        if (k == n) begin
                            slot_valid[k] = 1'b1;
                            slot_src[k]   = PW'(p);
                        end
                    end
                    rr_next = PW'((p + 1) % IN_PORTS);
                    n       = n + 1;
                end
            end
        end
    end

    // A granted arrival into an empty FIFO skips the FIFO only in the bypass build.
    always_comb begin
        overflow_event = 1'b0;
        for (int p = 0; p < IN_PORTS; p++) begin
`ifdef MRH_WB_ARB_BYPASS_EN
            bypass[p] = grant[p] && empty[p];
`else
            bypass[p] = 1'b0;
`endif
            pop[p]  = grant[p] && !empty[p];
            push[p] = i_tgt_valid[p] && !bypass[p] && (!full[p] || pop[p]);
            if (i_tgt_valid[p] && !bypass[p] && full[p] && !pop[p]) begin
                overflow_event = 1'b1;
            end
            count_next[p] = count[p] + {{AW{1'b0}}, push[p]} - {{AW{1'b0}}, pop[p]};
        end
        for (int k = 0; k < WR_PORTS; k++) begin
            slot_entry[k] = '0;
            for (int p = 0; p < IN_PORTS; p++) begin
                if (slot_valid[k] && slot_src[k] == PW'(p)) begin
                    slot_entry[k] = bypass[p] ? arrival[p] : head[p];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int p = 0; p < IN_PORTS; p++) begin
            if (push[p]) begin
                mem[p][wr_ptr[p][AW-1:0]] <= arrival[p];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int p = 0; p < IN_PORTS; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
            end
            rr_ptr      <= '0;
            o_stall_req <= '0;
            o_overflow  <= 1'b0;
        end else begin
            for (int p = 0; p < IN_PORTS; p++) begin
                if (push[p]) begin
                    wr_ptr[p] <= wr_ptr[p] + 1'b1;
                end
                if (pop[p]) begin
                    rd_ptr[p] <= rd_ptr[p] + 1'b1;
                end
                o_stall_req[p] <= (count_next[p] >= (AW+1)'(DEPTH - 2));
            end
            rr_ptr <= rr_next;
            if (overflow_event) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Write outputs are zero whenever the corresponding port is idle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wr_valid <= '0;
            o_wr_rnid  <= '0;
            o_wr_data  <= '0;
        end else begin
            for (int k = 0; k < WR_PORTS; k++) begin
                o_wr_valid[k]                <= slot_valid[k];
                o_wr_rnid[k*RNID_W +: RNID_W] <= slot_entry[k][EW-1 -: RNID_W];
                o_wr_data[k*XLEN +: XLEN]     <= slot_entry[k][XLEN-1:0];
            end
        end
    end

    generate
        for (genvar a = 0; a < WR_PORTS; a++) begin : g_dup_a
            for (genvar b = a + 1; b < WR_PORTS; b++) begin : g_dup_b
                a_no_dup_rnid : assert property (@(posedge i_clk) disable iff (!i_reset_n)
                    !(o_wr_valid[a] && o_wr_valid[b] &&
                      o_wr_rnid[a*RNID_W +: RNID_W] == o_wr_rnid[b*RNID_W +: RNID_W]));
            end
        end
    endgenerate

endmodule

// File: tb/tb_mrh_wb_arbiter.sv
// Scoreboard bench for mrh_wb_arbiter (default build): one single-write-port and one dual-write-port instance.
module tb_mrh_wb_arbiter;
    typedef struct {
        int         cyc;
        int         slot;
        logic [6:0] rnid;
        logic [63:0] data;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   valid1 = '0;
    logic [13:0]  rnid1 = '0;
    logic [127:0] data1 = '0;
    logic [1:0]   stall1;
    logic [0:0]   wr_valid1;
    logic [6:0]   wr_rnid1;
    logic [63:0]  wr_data1;
    logic         ovf1;
    logic [1:0]   valid2 = '0;
    logic [13:0]  rnid2 = '0;
    logic [127:0] data2 = '0;
    logic [1:0]   stall2;
    logic [1:0]   wr_valid2;
    logic [13:0]  wr_rnid2;
    logic [127:0] wr_data2;
    logic         ovf2;

    int   cyc = 0;
    int   base_cyc = 0;
    int   checks_total = 0;
    int   checks_passed = 0;
    exp_t q1[$];
    exp_t q2[$];
    logic [1:0] t2_valid [8];
    logic [1:0] t2_stall [8];

    localparam logic [63:0] DA = 64'hA000_0000;
    localparam logic [63:0] DB = 64'hB000_0000;
    localparam logic [63:0] DC = 64'hC000_0000;
    localparam logic [63:0] DD = 64'hD000_0000;

    mrh_wb_arbiter #(.IN_PORTS(2), .WR_PORTS(1), .DEPTH(4), .RNID_W(7), .XLEN(64)) dut1 (
        .i_clk(clock), .i_reset_n(~reset),
        .i_tgt_valid(valid1), .i_tgt_rnid(rnid1), .i_tgt_data(data1),
        .o_stall_req(stall1), .o_wr_valid(wr_valid1), .o_wr_rnid(wr_rnid1),
        .o_wr_data(wr_data1), .o_overflow(ovf1)
    );

    mrh_wb_arbiter #(.IN_PORTS(2), .WR_PORTS(2), .DEPTH(4), .RNID_W(7), .XLEN(64)) dut2 (
        .i_clk(clock), .i_reset_n(~reset),
        .i_tgt_valid(valid2), .i_tgt_rnid(rnid2), .i_tgt_data(data2),
        .o_stall_req(stall2), .o_wr_valid(wr_valid2), .o_wr_rnid(wr_rnid2),
        .o_wr_data(wr_data2), .o_overflow(ovf2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [6:0] rn(input int base, input int i);
        return 7'(base + i);
    endfunction

    function automatic logic [63:0] dv(input logic [63:0] base, input int i);
        return base + 64'(i);
    endfunction

    task automatic expect1(input int k, input logic [6:0] r, input logic [63:0] d);
        q1.push_back('{cyc: base_cyc + k, slot: 0, rnid: r, data: d});
    endtask

    task automatic expect2(input int k, input int s, input logic [6:0] r, input logic [63:0] d);
        q2.push_back('{cyc: base_cyc + k, slot: s, rnid: r, data: d});
    endtask

    task automatic applyStimulus(input int which, input logic [1:0] v, input logic [6:0] ra,
                                 input logic [63:0] da, input logic [6:0] rb, input logic [63:0] db);
        if (which == 1) begin
            valid1 = v;
            rnid1  = {rb, ra};
            data1  = {db, da};
        end else begin
            valid2 = v;
            rnid2  = {rb, ra};
            data2  = {db, da};
        end
        @(negedge clock);
    endtask

    task automatic idleCycles(input int n);
        valid1 = '0;
        valid2 = '0;
        repeat (n) @(negedge clock);
    endtask

    task automatic doReset(input string tag);
        @(negedge clock);
        valid1 = '0;
        valid2 = '0;
        reset  = 1'b1;
        #1;
        checkOutput({tag, "_wr_valid1"}, 128'(wr_valid1), 128'(0));
        checkOutput({tag, "_wr_rnid1"}, 128'(wr_rnid1), 128'(0));
        checkOutput({tag, "_wr_data1"}, 128'(wr_data1), 128'(0));
        checkOutput({tag, "_stall1"}, 128'(stall1), 128'(0));
        checkOutput({tag, "_ovf1"}, 128'(ovf1), 128'(0));
        checkOutput({tag, "_wr_valid2"}, 128'(wr_valid2), 128'(0));
        checkOutput({tag, "_ovf2"}, 128'(ovf2), 128'(0));
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Monitor: every write presented by either instance is matched against the scoreboard head.
    always @(negedge clock) begin
        exp_t e;
        if (wr_valid1[0]) begin
            if (q1.size() == 0) begin
                checkOutput("dut1_unexpected_write", 128'(wr_valid1), 128'(0));
            end else begin
                e = q1.pop_front();
                checkOutput("dut1_cycle", 128'(cyc), 128'(e.cyc));
                checkOutput("dut1_rnid", 128'(wr_rnid1), 128'(e.rnid));
                checkOutput("dut1_data", 128'(wr_data1), 128'(e.data));
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (wr_valid2[k]) begin
                if (q2.size() == 0) begin
                    checkOutput("dut2_unexpected_write", 128'(wr_valid2[k]), 128'(0));
                end else begin
                    e = q2.pop_front();
                    checkOutput("dut2_cycle", 128'(cyc), 128'(e.cyc));
                    checkOutput("dut2_slot", 128'(k), 128'(e.slot));
                    checkOutput("dut2_rnid", 128'(wr_rnid2[k*7 +: 7]), 128'(e.rnid));
                    checkOutput("dut2_data", 128'(wr_data2[k*64 +: 64]), 128'(e.data));
                end
            end
        end
    end

    initial begin
        t2_valid = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 2'b10, 2'b11};
        t2_stall = '{2'b00, 2'b00, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00, 2'b00};

        doReset("rst0");

        // Single result: pushed at edge 1, written after edge 2, one cycle only.
        base_cyc = cyc;
        expect1(2, 7'h05, 64'hDEAD);
        applyStimulus(1, 2'b01, 7'h05, 64'hDEAD, 7'h00, 64'h0);
        idleCycles(5);
        checkOutput("t1_drained", 128'(q1.size()), 128'(0));

        // Both pipes issue, honouring stall one cycle late; writes alternate port0/port1.
        doReset("rst1");
        base_cyc = cyc;
        expect1(2, rn(16, 1), dv(DA, 1));
        expect1(3, rn(48, 1), dv(DB, 1));
        expect1(4, rn(16, 2), dv(DA, 2));
        expect1(5, rn(48, 2), dv(DB, 2));
        expect1(6, rn(16, 3), dv(DA, 3));
        expect1(7, rn(48, 3), dv(DB, 3));
        expect1(8, rn(16, 4), dv(DA, 4));
        expect1(9, rn(48, 7), dv(DB, 7));
        expect1(10, rn(16, 8), dv(DA, 8));
        expect1(11, rn(48, 8), dv(DB, 8));
        for (int c = 1; c <= 8; c++) begin
            checkOutput($sformatf("t2_stall_c%0d", c), 128'(stall1), 128'(t2_stall[c-1]));
            applyStimulus(1, t2_valid[c-1], rn(16, c), dv(DA, c), rn(48, c), dv(DB, c));
        end
        idleCycles(5);
        checkOutput("t2_drained", 128'(q1.size()), 128'(0));
        checkOutput("t2_no_overflow", 128'(ovf1), 128'(0));
        checkOutput("t2_stall_idle", 128'(stall1), 128'(0));

        // Saturate both pipes ignoring stall: full push+pop keeps order, B8 is dropped.
        doReset("rst2");
        base_cyc = cyc;
        for (int i = 1; i <= 7; i++) begin
            expect1(2 * i, rn(16, i), dv(DA, i));
            expect1(2 * i + 1, rn(48, i), dv(DB, i));
        end
        expect1(16, rn(16, 8), dv(DA, 8));
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) begin
                checkOutput("t3_stall_full", 128'(stall1), 128'(2'b11));
            end
            applyStimulus(1, 2'b11, rn(16, c), dv(DA, c), rn(48, c), dv(DB, c));
            if (c == 7) begin
                checkOutput("t3_full_pushpop_no_ovf", 128'(ovf1), 128'(0));
            end
            if (c == 8) begin
                checkOutput("t3_overflow_set", 128'(ovf1), 128'(1));
            end
        end
        idleCycles(10);
        checkOutput("t3_drained", 128'(q1.size()), 128'(0));
        checkOutput("t3_overflow_sticky", 128'(ovf1), 128'(1));

        // Two write ports: grants follow rr_ptr order across slots.
        doReset("rst3");
        base_cyc = cyc;
        expect2(2, 0, rn(64, 1), dv(DC, 1));
        expect2(3, 0, rn(80, 2), dv(DD, 2));
        expect2(3, 1, rn(64, 2), dv(DC, 2));
        expect2(4, 0, rn(80, 3), dv(DD, 3));
        expect2(5, 0, rn(64, 4), dv(DC, 4));
        expect2(5, 1, rn(80, 4), dv(DD, 4));
        applyStimulus(2, 2'b10, 7'h0, 64'h0, rn(64, 1), dv(DC, 1));
        applyStimulus(2, 2'b11, rn(80, 2), dv(DD, 2), rn(64, 2), dv(DC, 2));
        applyStimulus(2, 2'b01, rn(80, 3), dv(DD, 3), 7'h0, 64'h0);
        applyStimulus(2, 2'b11, rn(80, 4), dv(DD, 4), rn(64, 4), dv(DC, 4));
        idleCycles(4);
        checkOutput("t4_drained", 128'(q2.size()), 128'(0));

        // Reset mid-drain with three entries buffered: nothing stale afterwards.
        doReset("rst4");
        base_cyc = cyc;
        expect1(2, rn(16, 1), dv(DA, 1));
        applyStimulus(1, 2'b11, rn(16, 1), dv(DA, 1), rn(48, 1), dv(DB, 1));
        applyStimulus(1, 2'b11, rn(16, 2), dv(DA, 2), rn(48, 2), dv(DB, 2));
        valid1 = '0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t5_wr_valid_zero", 128'(wr_valid1), 128'(0));
        checkOutput("t5_wr_rnid_zero", 128'(wr_rnid1), 128'(0));
        checkOutput("t5_wr_data_zero", 128'(wr_data1), 128'(0));
        checkOutput("t5_stall_zero", 128'(stall1), 128'(0));
        repeat (2) @(negedge clock);
        reset = 1'b0;
        base_cyc = cyc;
        expect1(2, 7'h66, 64'h1234);
        applyStimulus(1, 2'b10, 7'h0, 64'h0, 7'h66, 64'h1234);
        idleCycles(6);
        checkOutput("t5_drained", 128'(q1.size()), 128'(0));

        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
